// File: rtl/key_debounce_pulse_if.sv
// Key bus between the raw push-button pins and the debounce front end.
// master: the side that owns the pins (board or testbench).
// slave: the conditioner that drives the pulse and level outputs.
interface key_debounce_pulse_if;
    logic [4:0] Key_In;
    logic [4:0] Key_Pulse;
    logic [4:0] Key_State;

    modport master (
        output Key_In,
        input  Key_Pulse,
        input  Key_State
    );

    modport slave (
        input  Key_In,
        output Key_Pulse,
        output Key_State
    );
endinterface

// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse: five-key push-button conditioner.
// Raw active-low pins are synchronized, debounced per key, and turned into
// one-cycle active-high command pulses plus a debounced held level.
// Define KEY_AUTO_REPEAT_EN to add hold-to-repeat pulses. Without it the
// REPEAT_* parameters are ignored.
module key_debounce_pulse #(
    parameter logic [24:0] DEBOUNCE_CYCLES = 25'd1_000_000,
    parameter logic [24:0] REPEAT_DELAY    = 25'd25_000_000,
    parameter logic [24:0] REPEAT_PERIOD   = 25'd5_000_000
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    key_debounce_pulse_if.slave  keys
);

    localparam logic [1:0] ST_RELEASED    = 2'd0;
    localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
    localparam logic [1:0] ST_PRESSED     = 2'd2;
    localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

    localparam logic [24:0] DB_LAST = DEBOUNCE_CYCLES - 25'd1;
`ifdef KEY_AUTO_REPEAT_EN
    localparam logic [24:0] RD_LAST = REPEAT_DELAY - 25'd1;
    localparam logic [24:0] RP_LAST = REPEAT_PERIOD - 25'd1;
`endif

    logic [4:0] sync_meta;
    logic [4:0] sync_level;

    // Two-flop synchronizer. It resets to "released" so that a key held through reset is seen as a fresh press.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync_meta  <= 5'b11111;
            sync_level <= 5'b11111;
        end else begin
            sync_meta  <= keys.Key_In;
            sync_level <= sync_meta;
        end
    end

    genvar i;
    generate
        for (i = 0; i < 5; i++) begin : g_key
            logic [1:0]  fsm;
            logic [24:0] cnt;
            logic        pulse_r;
            logic        state_r;
`ifdef KEY_AUTO_REPEAT_EN
            logic [24:0] rpt_cnt;
            logic        rpt_armed;
`endif

            // Per-key debounce FSM. The counter only ever counts up to DB_LAST, so it cannot wrap.
            always_ff @(posedge CLK or negedge RSTn) begin
                if (!RSTn) begin
                    fsm       <= ST_RELEASED;
                    cnt       <= '0;
                    pulse_r   <= 1'b0;
                    state_r   <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
                    rpt_cnt   <= '0;
                    rpt_armed <= 1'b0;
`endif
                end else begin
                    pulse_r <= 1'b0;
                    case (fsm)
                        ST_RELEASED: begin
                            if (!sync_level[i]) begin
                                fsm <= ST_PRESS_CHK;
                                cnt <= '0;
                            end
                        end
                        ST_PRESS_CHK: begin
                            if (sync_level[i]) begin
                                fsm <= ST_RELEASED;
                                cnt <= '0;
                            end else if (cnt >= DB_LAST) begin
                                fsm       <= ST_PRESSED;
                                cnt       <= '0;
                                pulse_r   <= 1'b1;
                                state_r   <= 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
                                rpt_cnt   <= '0;
                                rpt_armed <= 1'b0;
`endif
                            end else begin
                                cnt <= cnt + 25'd1;
                            end
                        end
                        ST_PRESSED: begin
                            if (sync_level[i]) begin
                                fsm <= ST_RELEASE_CHK;
                                cnt <= '0;
`ifdef KEY_AUTO_REPEAT_EN
                            end else if (rpt_cnt >= (rpt_armed ? RP_LAST : RD_LAST)) begin
                                pulse_r   <= 1'b1;
                                rpt_cnt   <= '0;
                                rpt_armed <= 1'b1;
                            end else begin
                                rpt_cnt <= rpt_cnt + 25'd1;
`endif
                            end
                        end
                        default: begin
                            if (!sync_level[i]) begin
                                fsm       <= ST_PRESSED;
                                cnt       <= '0;
`ifdef KEY_AUTO_REPEAT_EN
                                rpt_cnt   <= '0;
                                rpt_armed <= 1'b0;
`endif
                            end else if (cnt >= DB_LAST) begin
                                fsm     <= ST_RELEASED;
                                cnt     <= '0;
                                state_r <= 1'b0;
                            end else begin
                                cnt <= cnt + 25'd1;
                            end
                        end
                    endcase
                end
            end

            assign keys.Key_Pulse[i] = pulse_r;
            assign keys.Key_State[i] = state_r;
        end
    endgenerate

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Scoreboard bench for key_debounce_pulse (DEBOUNCE_CYCLES=8, REPEAT_DELAY=40,
// REPEAT_PERIOD=16). Build with KEY_AUTO_REPEAT_EN to expect the repeat pulses.
module tb_key_debounce_pulse;

    localparam logic [24:0] DB = 25'd8;
    localparam logic [24:0] RD = 25'd40;
    localparam logic [24:0] RP = 25'd16;

    logic CLK  = 1'b0;
    logic RSTn = 1'b1;
    int   cyc  = 0;

    key_debounce_pulse_if key_bus ();

    key_debounce_pulse #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .CLK (CLK),
        .RSTn(RSTn),
        .keys(key_bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [4:0] pulse;
    } pulse_exp_t;

    typedef struct {
        int         at;
        logic [4:0] mask;
        logic [4:0] val;
    } state_exp_t;

    pulse_exp_t pulse_q[$];
    state_exp_t state_q[$];
    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drive the pins at a falling edge; t0 is the index of the first rising edge that samples them.
    task automatic applyStimulus(input logic [4:0] pins, output int t0);
        @(negedge CLK);
        key_bus.Key_In = pins;
        t0 = cyc + 1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic expectPulse(input int at, input logic [4:0] val);
        pulse_exp_t e;
        e.at    = at;
        e.pulse = val;
        pulse_q.push_back(e);
    endtask

    task automatic expectState(input int at, input logic [4:0] mask, input logic [4:0] val);
        state_exp_t e;
        e.at   = at;
        e.mask = mask;
        e.val  = val;
        state_q.push_back(e);
    endtask

    // Monitor: every nonzero Key_Pulse pops the pulse scoreboard; state expectations fire on their cycle.
    initial begin
        forever begin
            @(negedge CLK);
            while (pulse_q.size() > 0 && pulse_q[0].at < cyc) begin
                checkOutput("missing_pulse", 0, int'(pulse_q[0].pulse));
                void'(pulse_q.pop_front());
            end
            if (key_bus.Key_Pulse !== 5'b00000) begin
                if (pulse_q.size() > 0 && pulse_q[0].at == cyc) begin
                    checkOutput("pulse_value", int'(key_bus.Key_Pulse), int'(pulse_q[0].pulse));
                    void'(pulse_q.pop_front());
                end else begin
                    checkOutput("unexpected_pulse", int'(key_bus.Key_Pulse), 0);
                end
            end
            for (int k = state_q.size() - 1; k >= 0; k--) begin
                if (state_q[k].at <= cyc) begin
                    if (state_q[k].at == cyc)
                        checkOutput("key_state", int'(key_bus.Key_State & state_q[k].mask), int'(state_q[k].val));
                    else
                        checkOutput("stale_state_check", int'(state_q[k].at), cyc);
                    state_q.delete(k);
                end
            end
        end
    end

    initial begin
        int t0;
        int t1;
        int tb;
        int tr;

        key_bus.Key_In = 5'b11111;
        #2 RSTn = 1'b0;
        #1;
        checkOutput("reset_pulse", int'(key_bus.Key_Pulse), 0);
        checkOutput("reset_state", int'(key_bus.Key_State), 0);
        waitCycles(3);
        RSTn = 1'b1;
        waitCycles(5);

        // Clean press of key 2, held 100 samples, then released.
        $display("[TB] clean press / hold on key 2");
        applyStimulus(5'b11011, t0);
        expectPulse(t0 + 10, 5'b00100);
`ifdef KEY_AUTO_REPEAT_EN
        expectPulse(t0 + 50, 5'b00100);
        expectPulse(t0 + 66, 5'b00100);
        expectPulse(t0 + 82, 5'b00100);
        expectPulse(t0 + 98, 5'b00100);
`endif
        expectState(t0 + 9, 5'b00100, 5'b00000);
        expectState(t0 + 10, 5'b00100, 5'b00100);
        expectState(t0 + 60, 5'b11111, 5'b00100);
        waitCycles(99);
        applyStimulus(5'b11111, t1);
        expectState(t1 + 9, 5'b00100, 5'b00100);
        expectState(t1 + 10, 5'b00100, 5'b00000);
        waitCycles(30);

        // Bouncing key 4: 5 low samples, 2 high samples, six times.
        $display("[TB] bounce on key 4");
        tb = 0;
        for (int r = 0; r < 6; r++) begin
            applyStimulus(5'b01111, t0);
            if (r == 0) begin
                tb = t0;
                for (int k = 0; k <= 60; k += 6)
                    expectState(tb + k, 5'b10000, 5'b00000);
            end
            waitCycles(4);
            applyStimulus(5'b11111, t0);
            waitCycles(1);
        end
        waitCycles(30);

        // Keys 1 and 3 pressed on the same edge.
        $display("[TB] simultaneous keys 1 and 3");
        applyStimulus(5'b10101, t0);
        expectPulse(t0 + 10, 5'b01010);
        expectState(t0 + 9, 5'b01010, 5'b00000);
        expectState(t0 + 10, 5'b01010, 5'b01010);
        waitCycles(19);
        applyStimulus(5'b11111, t1);
        expectState(t1 + 10, 5'b01010, 5'b00000);
        waitCycles(30);

        // Reset while key 0 is mid-debounce; the key stays held through reset.
        $display("[TB] reset during key 0 press check");
        applyStimulus(5'b11110, t0);
        waitCycles(5);
        RSTn = 1'b0;
        #1;
        checkOutput("midreset_pulse", int'(key_bus.Key_Pulse), 0);
        checkOutput("midreset_state", int'(key_bus.Key_State), 0);
        waitCycles(2);
        RSTn = 1'b1;
        tr = cyc + 1;
        expectPulse(tr + 10, 5'b00001);
        expectState(tr + 9, 5'b00001, 5'b00000);
        expectState(tr + 10, 5'b00001, 5'b00001);
        waitCycles(20);
        applyStimulus(5'b11111, t1);
        expectState(t1 + 10, 5'b00001, 5'b00000);
        waitCycles(30);

        while (pulse_q.size() > 0) begin
            checkOutput("missing_pulse", 0, int'(pulse_q[0].pulse));
            void'(pulse_q.pop_front());
        end
        while (state_q.size() > 0) begin
            checkOutput("unchecked_state", 0, int'(state_q[0].at));
            void'(state_q.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
